comparator_scan_ctrl: RTL and testbench
=======================================

# comparator_scan_ctrl

Digital sequencer that shares one 3.3 V analog comparator between up to NCH input pairs. It drives the analog-mux select and the comparator enable, waits a programmable settling time, and samples the comparator output through a synchronizer. It then majority-votes NSAMP samples and stores one result bit per channel. It sits on the core clock domain between the register bank (control and status) and the analog comparator macro.

## Interface
Parameters:
- NCH, 4: number of comparator input pairs (2..8).
- SETTLE_W, 8: width of the settle-count input.
- NSAMP, 3: samples per channel; must be odd, majority vote.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- resetn  in  1  reset; one clock, asynchronous assert, active-low.
- start  in  1  one-cycle pulse that begins a scan; ignored while busy.
- cont  in  1  continuous mode; rescan immediately after each DONE while high.
- ch_mask  in  NCH  channels to scan; latched at scan start.
- settle_cycles  in  SETTLE_W  settle wait per channel; latched at scan start.
- irq_clr  in  1  clears irq.
- cmp_out  in  1  comparator OUT; asynchronous to clk.
- cmp_en  out  1  comparator EN.
- cmp_sel  out  $clog2(NCH)  analog-mux channel select.
- result  out  NCH  latest voted comparison per channel (1 = INP > INN).
- result_valid  out  1  one-cycle pulse at end of each scan.
- busy  out  1  high in every state except IDLE.
- irq  out  1  sticky change flag.

## Operation
States and transitions:
- IDLE → SEL on start (or on cont high) when the latched mask is nonzero, loading the lowest set channel into cmp_sel.
- IDLE → DONE directly when the latched mask is zero. result is unchanged and result_valid still pulses.
- SEL (1 cycle) sets cmp_en = 1, loads the settle counter, then goes to SETTLE.
- SETTLE counts settle_cycles cycles. A value of 0 skips SETTLE and goes straight to SAMPLE.
- SAMPLE takes NSAMP consecutive synchronized samples and counts the ones.
- NEXT (1 cycle) writes result[cmp_sel] = (ones > NSAMP/2). It then moves cmp_sel to the next higher set mask bit and goes to SEL, or goes to DONE if none remain.
- DONE (1 cycle) pulses result_valid and sets cmp_en = 0. It goes to SEL of the lowest masked channel if cont = 1 and the relatched mask is nonzero; otherwise it goes to IDLE.

Rules:
- cmp_en is high in SEL, SETTLE, SAMPLE and NEXT; it stays high across channel changes.
- cmp_sel changes only on entry to SEL and holds its value in IDLE and DONE.
- Unmasked result bits keep their previous value.
- irq sets in the DONE cycle when any masked bit of the new result differs from its pre-scan value.
- irq_clr clears irq; if set and clear coincide, set wins.
- cont deasserting mid-scan finishes the current scan, then returns to IDLE.
- start during busy is ignored. ch_mask and settle_cycles changes mid-scan take effect at the next scan.

## Timing
- Reset (async) forces: state IDLE, cmp_en 0, cmp_sel 0, result 0, result_valid 0, busy 0, irq 0, synchronizer flops 0.
- Reset mid-scan drops cmp_en in the same instant, without waiting for a clock.
- Synchronizer is 2 flops: a sample in SAMPLE reflects cmp_out 2 cycles earlier. settle_cycles ≥ 2 guarantees every sample post-dates the mux switch; smaller values are legal but unguarded.
- Per enabled channel: 1 (SEL) + settle_cycles + NSAMP + 1 (NEXT) cycles.
- Scan latency: start edge → result_valid = Σ(channel cost) + 1 cycle.
- busy rises the cycle after start is sampled and falls on return to IDLE.

## Structure
- Package comparator_scan_pkg holds:
  - the state enum (IDLE, SEL, SETTLE, SAMPLE, NEXT, DONE);
  - a next-set-channel helper function (priority search above the current index, returns a found flag);
  - the majority-threshold constant.
- One sub-module, cmp_sync: a 2-flop synchronizer with async active-low reset, used for cmp_out.
- Sample counter width is $clog2(NSAMP+1).

## Test plan
- Reset mid-scan: assert resetn low during SETTLE → cmp_en, busy, result and irq read 0 immediately, and after release the block sits in IDLE.
- Single channel: mask = 4'b0100, settle = 5, cmp_out held 1, start → cmp_sel = 2, cmp_en high for 10 cycles, result = 4'b0100, result_valid at start+11 cycles, irq = 1.
- Sparse mask with noise: mask = 4'b1001, cmp_out pattern 1,0,1 during ch0 SAMPLE and 0,0,1 during ch3 SAMPLE → result[0] = 1, result[3] = 0; cmp_sel visits 0 then 3, skipping 1 and 2.
- Boundaries: mask = 0 with start → result_valid the cycle after IDLE, cmp_en never high. settle = 0 → SAMPLE immediately follows SEL. start while busy → no restart.
- Continuous mode: cont = 1 with an identical input on each pass → back-to-back scans with one DONE cycle between them and irq set only once. Drop cont mid-scan → the scan completes, then IDLE.
- irq collision: result change and irq_clr in the same DONE cycle → irq = 1; irq_clr alone the next cycle → irq = 0.

Source files
------------

// File: rtl/comparator_scan_ctrl_pkg.sv
// Shared types and helpers for the comparator scan sequencer: FSM encoding,
// majority threshold and the set-bit search used to walk the channel mask.
package comparator_scan_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEL    = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    NEXT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Mask search is sized for the largest supported channel count.
  localparam int MAX_CH   = 8;
  localparam int CH_IDX_W = 3;

  typedef struct packed {
    logic                found;
    logic [CH_IDX_W-1:0] idx;
  } ch_hit_t;

  // A channel reads 1 when strictly more than this many samples were high.
  function automatic int maj_thresh(input int nsamp);
    return nsamp / 2;
  endfunction

  // Lowest set mask bit strictly above cur, or the lowest set bit overall
  // when from_base is high.
  function automatic ch_hit_t next_set_ch(input logic [MAX_CH-1:0]   mask,
                                          input logic [CH_IDX_W-1:0] cur,
                                          input logic                from_base);
    ch_hit_t hit;
    hit = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (from_base || (i > int'(cur)))) begin
        hit.found = 1'b1;
        hit.idx   = CH_IDX_W'(i);
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/comparator_scan_ctrl_sync.sv
// Two-flop synchronizer bringing the asynchronous comparator output into
// the core clock domain.
module cmp_sync (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/comparator_scan_ctrl.sv
// Time-shares one analog comparator across NCH input pairs: selects each
// masked channel, waits for settling, majority-votes NSAMP samples, stores results.
module comparator_scan_ctrl
  import comparator_scan_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int SETTLE_W = 8,
  parameter int NSAMP    = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    cont,
  input  logic [NCH-1:0]          ch_mask,
  input  logic [SETTLE_W-1:0]     settle_cycles,
  input  logic                    irq_clr,
  input  logic                    cmp_out,
  output logic                    cmp_en,
  output logic [$clog2(NCH)-1:0]  cmp_sel,
  output logic [NCH-1:0]          result,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    irq
);

  localparam int SEL_W = $clog2(NCH);
  localparam int CNT_W = $clog2(NSAMP + 1);
  localparam logic [CNT_W-1:0] MAJ       = CNT_W'(maj_thresh(NSAMP));
  localparam logic [CNT_W-1:0] LAST_SAMP = CNT_W'(NSAMP - 1);

  state_t              state;
  state_t              state_n;
  logic [NCH-1:0]      mask_lat;
  logic [SETTLE_W-1:0] settle_lat;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [CNT_W-1:0]    samp_cnt;
  logic [CNT_W-1:0]    ones;
  logic [NCH-1:0]      result_pre;
  logic                cmp_s;
  logic                scan_load;
  logic                irq_set;
  ch_hit_t             hit_first;
  ch_hit_t             hit_next;

  cmp_sync u_cmp_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (cmp_out),
    .q      (cmp_s)
  );

  // First channel is searched in the live mask because it is latched on
  // the same edge that enters SEL.
  assign hit_first = next_set_ch(MAX_CH'(ch_mask), '0, 1'b1);
  assign hit_next  = next_set_ch(MAX_CH'(mask_lat), CH_IDX_W'(cmp_sel), 1'b0);

  assign scan_load = ((state == IDLE) && (start || cont)) ||
                     ((state == DONE) && cont);

  // Only masked channels count as a change; result is final by DONE.
  assign irq_set = (state == DONE) && (|((result ^ result_pre) & mask_lat));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start || cont) begin
          state_n = hit_first.found ? SEL : DONE;
        end
      end
      SEL:    state_n = (settle_lat == '0) ? SAMPLE : SETTLE;
      SETTLE: begin
        if (settle_cnt == SETTLE_W'(1)) begin
          state_n = SAMPLE;
        end
      end
      SAMPLE: begin
        if (samp_cnt == LAST_SAMP) begin
          state_n = NEXT;
        end
      end
      NEXT:   state_n = hit_next.found ? SEL : DONE;
      DONE:   state_n = (cont && hit_first.found) ? SEL : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Decoded from the state register so an async reset drops cmp_en at once.
  always_comb begin
    cmp_en       = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    case (state)
      IDLE:                      busy         = 1'b0;
      SEL, SETTLE, SAMPLE, NEXT: cmp_en       = 1'b1;
      DONE:                      result_valid = 1'b1;
      default:                   busy         = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mask_lat   <= '0;
      settle_lat <= '0;
      settle_cnt <= '0;
      samp_cnt   <= '0;
      ones       <= '0;
      result     <= '0;
      result_pre <= '0;
      cmp_sel    <= '0;
    end else begin
      if (scan_load) begin
        mask_lat   <= ch_mask;
        settle_lat <= settle_cycles;
        result_pre <= result;
        if (hit_first.found) begin
          cmp_sel <= SEL_W'(hit_first.idx);
        end
      end
      case (state)
        SEL: begin
          settle_cnt <= settle_lat;
          samp_cnt   <= '0;
          ones       <= '0;
        end
        SETTLE: settle_cnt <= settle_cnt - SETTLE_W'(1);
        SAMPLE: begin
          samp_cnt <= samp_cnt + CNT_W'(1);
          ones     <= ones + CNT_W'(cmp_s);
        end
        NEXT: begin
          result[cmp_sel] <= (ones > MAJ);
          if (hit_next.found) begin
            cmp_sel <= SEL_W'(hit_next.idx);
          end
        end
        default: ;
      endcase
    end
  end

  // A new change outranks a coincident clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq <= 1'b0;
    end else if (irq_set) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_comparator_scan_ctrl.sv
// Directed bench for comparator_scan_ctrl: reset, single/sparse scans,
// boundary settle/mask cases, continuous mode and irq set/clear priority.
module tb_comparator_scan_ctrl;

  localparam int NCH      = 4;
  localparam int SETTLE_W = 8;
  localparam int NSAMP    = 3;

  logic                clk = 1'b0;
  logic                resetn;
  logic                start;
  logic                cont;
  logic [NCH-1:0]      ch_mask;
  logic [SETTLE_W-1:0] settle_cycles;
  logic                irq_clr;
  logic                cmp_out;
  logic                cmp_en;
  logic [1:0]          cmp_sel;
  logic [NCH-1:0]      result;
  logic                result_valid;
  logic                busy;
  logic                irq;

  int   vectors     = 0;
  int   miscompares = 0;
  int   en_cycles;
  logic saw_skip;
  logic pat [0:15];

  comparator_scan_ctrl #(
    .NCH      (NCH),
    .SETTLE_W (SETTLE_W),
    .NSAMP    (NSAMP)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .cont          (cont),
    .ch_mask       (ch_mask),
    .settle_cycles (settle_cycles),
    .irq_clr       (irq_clr),
    .cmp_out       (cmp_out),
    .cmp_en        (cmp_en),
    .cmp_sel       (cmp_sel),
    .result        (result),
    .result_valid  (result_valid),
    .busy          (busy),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; cont = 1'b0; irq_clr = 1'b0;
    cmp_out = 1'b0; ch_mask = '0; settle_cycles = '0;
    #2;
    check("rst_cmp_en", cmp_en, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_rv", result_valid, 0);
    check("rst_irq", irq, 0);
    check("rst_sel", cmp_sel, 0);
    tick(2);
    resetn = 1'b1;
    tick(2);

    // Single channel, settle 5, comparator high; start pulse while busy ignored
    ch_mask = 4'b0100; settle_cycles = 8'd5; cmp_out = 1'b1;
    tick(3);
    start = 1'b1; en_cycles = 0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      start = (c == 4);
      if (cmp_en) en_cycles++;
      if (c == 1) begin
        check("single_sel", cmp_sel, 2);
        check("single_busy", busy, 1);
      end
      if (c == 10) check("single_rv_early", result_valid, 0);
      if (c == 11) begin
        check("single_rv", result_valid, 1);
        check("single_result", result, 4'b0100);
        check("single_done_en", cmp_en, 0);
      end
      if (c == 12) begin
        check("single_irq", irq, 1);
        check("single_idle", busy, 0);
        irq_clr = 1'b1;
      end
      if (c == 13) begin
        check("single_irq_clr", irq, 0);
        irq_clr = 1'b0;
      end
    end
    check("single_en_cycles", en_cycles, 10);

    // Sparse mask with noisy samples; irq_clr coincides with the DONE cycle
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
            1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ch_mask = 4'b1001; settle_cycles = 8'd2;
    tick();
    start = 1'b1; cmp_out = pat[0]; saw_skip = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      tick();
      start = 1'b0;
      if (c <= 15) cmp_out = pat[c];
      if (busy && (cmp_sel == 2'd1 || cmp_sel == 2'd2)) saw_skip = 1'b1;
      if (c == 1) check("sparse_sel0", cmp_sel, 0);
      if (c == 8) check("sparse_sel3", cmp_sel, 3);
      if (c == 15) begin
        check("sparse_rv", result_valid, 1);
        check("sparse_result", result, 4'b0101);
        irq_clr = 1'b1;
      end
      if (c == 16) check("collide_irq_set_wins", irq, 1);
      if (c == 17) begin
        check("collide_irq_cleared", irq, 0);
        irq_clr = 1'b0;
      end
    end
    check("sparse_skip_1_2", saw_skip, 0);

    // Empty mask: straight to DONE, comparator never enabled
    ch_mask = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_rv", result_valid, 1);
    check("empty_en", cmp_en, 0);
    check("empty_busy", busy, 1);
    tick();
    check("empty_idle", busy, 0);
    check("empty_result", result, 4'b0101);
    check("empty_irq", irq, 0);

    // Zero settle: SAMPLE directly after SEL
    ch_mask = 4'b0010; settle_cycles = 8'd0; cmp_out = 1'b1;
    tick();
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start = 1'b0;
      if (c == 1) begin
        check("z_settle_sel", cmp_sel, 1);
        check("z_settle_en", cmp_en, 1);
      end
      if (c == 5) check("z_settle_rv_early", result_valid, 0);
      if (c == 6) begin
        check("z_settle_rv", result_valid, 1);
        check("z_settle_result", result, 4'b0111);
      end
      if (c == 7) begin
        check("z_settle_irq", irq, 1);
        irq_clr = 1'b1;
      end
      if (c == 8) begin
        check("z_settle_irq_clr", irq, 0);
        irq_clr = 1'b0;
      end
    end

    // Continuous mode: three passes, cont dropped during the third
    ch_mask = 4'b0001; settle_cycles = 8'd3; cmp_out = 1'b0;
    tick(3);
    cont = 1'b1;
    for (int c = 1; c <= 29; c++) begin
      tick();
      if (c == 9) begin
        check("cont_rv1", result_valid, 1);
        check("cont_done_en", cmp_en, 0);
        check("cont_done_busy", busy, 1);
        check("cont_result", result, 4'b0110);
      end
      if (c == 10) begin
        check("cont_irq1", irq, 1);
        check("cont_rescan_en", cmp_en, 1);
        check("cont_rescan_sel", cmp_sel, 0);
        irq_clr = 1'b1;
      end
      if (c == 11) begin
        check("cont_irq_clr", irq, 0);
        irq_clr = 1'b0;
      end
      if (c == 18) check("cont_rv2", result_valid, 1);
      if (c == 19) begin
        check("cont_irq_once", irq, 0);
        check("cont_pass3_busy", busy, 1);
      end
      if (c == 20) cont = 1'b0;
      if (c == 27) check("cont_rv3", result_valid, 1);
      if (c == 28) check("cont_stop_idle", busy, 0);
      if (c == 29) begin
        check("cont_no_rescan", busy, 0);
        check("cont_no_rv", result_valid, 0);
      end
    end

    // Asynchronous reset during SETTLE
    ch_mask = 4'b1111; settle_cycles = 8'd10; cmp_out = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    check("mid_settle_en", cmp_en, 1);
    #3;
    resetn = 1'b0;
    #1;
    check("async_rst_en", cmp_en, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_result", result, 0);
    check("async_rst_irq", irq, 0);
    tick(2);
    resetn = 1'b1;
    tick(3);
    check("post_rst_busy", busy, 0);
    check("post_rst_en", cmp_en, 0);
    check("post_rst_sel", cmp_sel, 0);
    check("post_rst_rv", result_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
